pattern_detect_ctrl: RTL and testbench
======================================

Name: pattern_detect_ctrl

Overview:
Run-time configurable serial pattern detector with a control FSM. It loads a pattern and mask through a valid/ready config port, gates detection until the shift window is full, and reports matches as one-cycle pulses. It also keeps a saturating match counter and supports overlapping or non-overlapping detection. It replaces fixed-function detectors in the serial-input sequence-detection path.

Parameters:
W, 5, pattern/shift window width in bits (≥2)
CNT_W, 8, match counter width (≥1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  config word present
cfg_ready  output  1  config accepted this cycle when cfg_valid=1; high only in IDLE
cfg_pattern  input  W  pattern to match
cfg_mask  input  W  per-bit compare enable (1 = compare)
cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
start  input  1  begin detection (honoured only in IDLE)
stop  input  1  abort to IDLE
in_valid  input  1  serial bit qualifier
in  input  1  serial data bit
z  output  1  registered one-cycle match pulse
match_count  output  CNT_W  saturating match count
overflow  output  1  sticky; increment attempted at saturation
busy  output  1  state != IDLE
armed  output  1  state == RUN

Behaviour:
- Reset (clk edge with reset=1) overrides everything:
  - state=IDLE, shift=0, fill_cnt=0, z=0, match_count=0, overflow=0.
  - pat_r=0, mask_r=all ones, ovl_r=1.
- Shift convention, applied on each accepted bit (in_valid=1 in FILL or RUN):
  - shift[W-1] <= in; shift[i] <= shift[i+1].
  - The oldest bit is at shift[0]. After bits b0..b(W-1) in time order, shift = {b(W-1),…,b0}.
- Match test uses the post-shift value: hit = ((next_shift ^ pat_r) & mask_r) == 0.
- IDLE:
  - cfg_ready=1. cfg_valid captures pat_r, mask_r and ovl_r.
  - in_valid is ignored; shift is held.
  - start=1 and stop=0 → FILL. On that edge, clear shift, fill_cnt, match_count and overflow.
  - A config captured on the same edge as start is in effect for the run.
- FILL:
  - Each accepted bit increments fill_cnt.
  - On the accepted bit that makes fill_cnt reach W, evaluate hit and go to RUN. Exception: if hit and ovl_r=0, go to FILL with fill_cnt=0.
  - No hit is evaluated for bits 1..W-1.
- RUN:
  - Evaluate hit on every accepted bit.
  - If hit and ovl_r=0 → FILL with fill_cnt=0. shift is not cleared, so the next match needs W fresh bits.
  - If hit and ovl_r=1 → stay in RUN.
- Hit side effects:
  - z=1 for exactly the cycle after the accepting edge; z=0 on all other cycles, including cycles with in_valid=0.
  - If match_count < all ones, match_count increments. Otherwise it holds and overflow is set.
  - overflow is cleared only by reset or start.
- in_valid=0 in FILL/RUN: shift, fill_cnt, state and count are all held.
- stop=1 in any state → IDLE on the next edge.
  - Takes priority over start and over a same-cycle hit; that hit produces no z and no count.
  - match_count and overflow are retained for readout.
- start in FILL or RUN is ignored.
- cfg_valid outside IDLE is ignored; cfg_ready=0 and config is unchanged.
- Latency: accepted bit → z is 1 clock. start → first possible z is W accepted bits later.

Test Plan:
1. Reset mid-RUN with in_valid=1 → next cycle: busy=0, z=0, match_count=0, cfg_ready=1; a following start with no new config gives mask=11111, pattern=0, overlap=1.
2. Config pattern=5'b00010, mask=11111, overlap=1; start; feed 0,1,0,0,0 → z pulses once, the cycle after the 5th bit; match_count=1; armed=1 from the 5th bit onward.
3. pattern=0, mask=11111: overlap=1, feed 7 zeros → 3 z pulses (bits 5,6,7), count=3; restart with overlap=0, feed 10 zeros → pulses at bits 5 and 10 only, count=2.
4. mask=11110, pattern=00010; feed 1,1,0,0,0 (shift=00011) → match (bit 0 ignored); change mask to 11111 in IDLE, repeat → no z. Insert in_valid=0 gaps between bits → identical result.
5. CNT_W=2, pattern=0, overlap=1, 8 zeros → count sequence 1,2,3,3; overflow=1 after the 4th match; start clears both to 0.
6. stop asserted on the cycle of a completing bit → no z, count unchanged, busy=0 next cycle; start+stop together in IDLE → stays IDLE; cfg_valid during RUN → cfg_ready=0, pattern unchanged.

Source files
------------

// File: rtl/pattern_detect_ctrl_if.sv
// Config, control, serial-input and status bundle for pattern_detect_ctrl.
// The master side drives configuration and bits; the slave side is the detector.
interface pattern_detect_ctrl_if #(
    parameter int W     = 5,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [W-1:0]     cfg_pattern;
    logic [W-1:0]     cfg_mask;
    logic             cfg_overlap;
    logic             start;
    logic             stop;
    logic             in_valid;
    logic             in;
    logic             z;
    logic [CNT_W-1:0] match_count;
    logic             overflow;
    logic             busy;
    logic             armed;

    modport master (
        output cfg_valid, cfg_pattern, cfg_mask, cfg_overlap,
        output start, stop, in_valid, in,
        input  cfg_ready, z, match_count, overflow, busy, armed
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_mask, cfg_overlap,
        input  start, stop, in_valid, in,
        output cfg_ready, z, match_count, overflow, busy, armed
    );
endinterface

// File: rtl/pattern_detect_ctrl.sv
// Run-time configurable serial pattern detector: masked compare over a W-bit
// shift window, fill gating, overlap control and a saturating match counter.
module pattern_detect_ctrl #(
    parameter int W     = 5,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    pattern_detect_ctrl_if.slave  bus
);
    localparam int FW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     shift, shift_nxt;
    logic [FW-1:0]    fill_cnt, fill_nxt;
    logic             z_r, z_nxt;
    logic [CNT_W-1:0] match_count, cnt_nxt;
    logic             overflow, ovf_nxt;
    logic [W-1:0]     pat_r, pat_nxt;
    logic [W-1:0]     mask_r, mask_nxt;
    logic             ovl_r, ovl_nxt;

    logic [W-1:0]     next_shift;
    logic             hit;
    logic             take_hit;

    // Oldest bit sits at shift[0]; the newest enters at the top.
    assign next_shift = {bus.in, shift[W-1:1]};
    assign hit        = ((next_shift ^ pat_r) & mask_r) == '0;

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        fill_nxt  = fill_cnt;
        z_nxt     = 1'b0;
        cnt_nxt   = match_count;
        ovf_nxt   = overflow;
        pat_nxt   = pat_r;
        mask_nxt  = mask_r;
        ovl_nxt   = ovl_r;
        take_hit  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.cfg_valid) begin
                    pat_nxt  = bus.cfg_pattern;
                    mask_nxt = bus.cfg_mask;
                    ovl_nxt  = bus.cfg_overlap;
                end
                if (bus.start && !bus.stop) begin
                    state_nxt = FILL;
                    shift_nxt = '0;
                    fill_nxt  = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            FILL: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (bus.in_valid) begin
                    shift_nxt = next_shift;
                    fill_nxt  = fill_cnt + FW'(1);
                    if (fill_cnt == FW'(W - 1)) begin
                        take_hit = hit;
                        if (hit && !ovl_r) fill_nxt  = '0;
                        else               state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (bus.in_valid) begin
                    shift_nxt = next_shift;
                    take_hit  = hit;
                    // Non-overlapping: the next match needs W fresh bits.
                    if (hit && !ovl_r) begin
                        state_nxt = FILL;
                        fill_nxt  = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (take_hit) begin
            z_nxt = 1'b1;
            if (&match_count) ovf_nxt = 1'b1;
            else              cnt_nxt = match_count + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            fill_cnt    <= '0;
            z_r         <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
            pat_r       <= '0;
            mask_r      <= '1;
            ovl_r       <= 1'b1;
        end else begin
            state       <= state_nxt;
            shift       <= shift_nxt;
            fill_cnt    <= fill_nxt;
            z_r         <= z_nxt;
            match_count <= cnt_nxt;
            overflow    <= ovf_nxt;
            pat_r       <= pat_nxt;
            mask_r      <= mask_nxt;
            ovl_r       <= ovl_nxt;
        end
    end

    assign bus.cfg_ready   = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.armed       = (state == RUN);
    assign bus.z           = z_r;
    assign bus.match_count = match_count;
    assign bus.overflow    = overflow;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, two detector
// instances (8-bit and 2-bit counters) driven identically, checked against a model.
module tb_pattern_detect_ctrl;
    localparam int W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         s_cfg_valid, s_cfg_overlap, s_start, s_stop, s_in_valid, s_in;
    logic [W-1:0] s_cfg_pattern, s_cfg_mask;

    pattern_detect_ctrl_if #(.W(W), .CNT_W(8)) bus0 ();
    pattern_detect_ctrl_if #(.W(W), .CNT_W(2)) bus1 ();

    assign bus0.cfg_valid = s_cfg_valid;   assign bus1.cfg_valid = s_cfg_valid;
    assign bus0.cfg_pattern = s_cfg_pattern; assign bus1.cfg_pattern = s_cfg_pattern;
    assign bus0.cfg_mask = s_cfg_mask;     assign bus1.cfg_mask = s_cfg_mask;
    assign bus0.cfg_overlap = s_cfg_overlap; assign bus1.cfg_overlap = s_cfg_overlap;
    assign bus0.start = s_start;           assign bus1.start = s_start;
    assign bus0.stop = s_stop;             assign bus1.stop = s_stop;
    assign bus0.in_valid = s_in_valid;     assign bus1.in_valid = s_in_valid;
    assign bus0.in = s_in;                 assign bus1.in = s_in;

    pattern_detect_ctrl #(.W(W), .CNT_W(8)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pattern_detect_ctrl #(.W(W), .CNT_W(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int tests = 0;
    int fails = 0;
    int zpulses;

    // Reference model: running flag, count of fresh bits, recent bit history.
    bit           m_run;
    int           m_fresh;
    bit           hist[$];
    logic [W-1:0] m_pat, m_mask;
    bit           m_ovl, m_z;
    int           m_cnt [2];
    bit           m_ovf [2];
    int           m_max [2] = '{255, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit window_matches();
        int n = hist.size();
        for (int i = 0; i < W; i++)
            if (m_mask[i] && (hist[n - W + i] != m_pat[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        m_z = 1'b0;
        if (reset) begin
            m_run = 0; m_fresh = 0; hist.delete();
            m_pat = '0; m_mask = '1; m_ovl = 1'b1;
            for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
        end else if (!m_run) begin
            if (s_cfg_valid) begin
                m_pat = s_cfg_pattern; m_mask = s_cfg_mask; m_ovl = s_cfg_overlap;
            end
            if (s_start && !s_stop) begin
                m_run = 1; m_fresh = 0; hist.delete();
                for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
            end
        end else if (s_stop) begin
            m_run = 0;
        end else if (s_in_valid) begin
            hist.push_back(s_in);
            if (hist.size() > W) void'(hist.pop_front());
            if (m_fresh < W) m_fresh++;
            if (m_fresh >= W && window_matches()) begin
                m_z = 1'b1;
                for (int k = 0; k < 2; k++)
                    if (m_cnt[k] == m_max[k]) m_ovf[k] = 1'b1;
                    else m_cnt[k]++;
                if (!m_ovl) m_fresh = 0;
            end
        end
    endtask

    task automatic compare_all();
        bit exp_armed = m_run && (m_fresh >= W);
        check("z0", 32'(bus0.z), 32'(m_z));
        check("z1", 32'(bus1.z), 32'(m_z));
        check("count0", 32'(bus0.match_count), 32'(m_cnt[0]));
        check("count1", 32'(bus1.match_count), 32'(m_cnt[1]));
        check("ovf0", 32'(bus0.overflow), 32'(m_ovf[0]));
        check("ovf1", 32'(bus1.overflow), 32'(m_ovf[1]));
        check("busy0", 32'(bus0.busy), 32'(m_run));
        check("busy1", 32'(bus1.busy), 32'(m_run));
        check("armed0", 32'(bus0.armed), 32'(exp_armed));
        check("armed1", 32'(bus1.armed), 32'(exp_armed));
        check("ready0", 32'(bus0.cfg_ready), 32'(!m_run));
        check("ready1", 32'(bus1.cfg_ready), 32'(!m_run));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (bus0.z) zpulses++;
    endtask

    task automatic idle_inputs();
        reset = 0; s_cfg_valid = 0; s_cfg_overlap = 0; s_start = 0; s_stop = 0;
        s_in_valid = 0; s_in = 0; s_cfg_pattern = '0; s_cfg_mask = '0;
    endtask

    task automatic feed(input bit b);
        s_in_valid = 1; s_in = b; tick(); s_in_valid = 0;
    endtask

    task automatic configure(input logic [W-1:0] p, input logic [W-1:0] m, input bit o);
        s_cfg_valid = 1; s_cfg_pattern = p; s_cfg_mask = m; s_cfg_overlap = o;
        tick(); s_cfg_valid = 0;
    endtask

    task automatic do_start();
        s_start = 1; tick(); s_start = 0;
    endtask

    task automatic do_stop();
        s_stop = 1; tick(); s_stop = 0;
    endtask

    logic [W-1:0] seq4;

    initial begin
        idle_inputs();
        reset = 1; tick(); tick(); reset = 0;
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_count", 32'(bus0.match_count), 32'd0);

        // 1: reset mid-run, then defaults (pattern 0, mask ones, overlap) apply
        configure(5'b10101, 5'b11111, 1'b0); do_start();
        feed(1); feed(0);
        s_in_valid = 1; s_in = 1; reset = 1; tick(); reset = 0; s_in_valid = 0;
        check("t1_busy", 32'(bus0.busy), 32'd0);
        check("t1_z", 32'(bus0.z), 32'd0);
        check("t1_ready", 32'(bus0.cfg_ready), 32'd1);
        do_start();
        zpulses = 0;
        for (int i = 0; i < 6; i++) feed(0);
        check("t1_default_pulses", 32'(zpulses), 32'd2);
        do_stop();

        // 2: single pattern match after exactly W bits
        configure(5'b00010, 5'b11111, 1'b1); do_start();
        feed(0); feed(1); feed(0); feed(0);
        check("t2_not_armed", 32'(bus0.armed), 32'd0);
        feed(0);
        check("t2_z", 32'(bus0.z), 32'd1);
        check("t2_armed", 32'(bus0.armed), 32'd1);
        check("t2_count", 32'(bus0.match_count), 32'd1);
        tick();
        check("t2_z_low", 32'(bus0.z), 32'd0);
        do_stop();

        // 3: overlap vs non-overlap on a run of zeros
        configure(5'b00000, 5'b11111, 1'b1); do_start();
        zpulses = 0;
        for (int i = 0; i < 7; i++) feed(0);
        check("t3_ovl_pulses", 32'(zpulses), 32'd3);
        check("t3_ovl_count", 32'(bus0.match_count), 32'd3);
        do_stop();
        configure(5'b00000, 5'b11111, 1'b0); do_start();
        zpulses = 0;
        for (int i = 0; i < 10; i++) feed(0);
        check("t3_novl_pulses", 32'(zpulses), 32'd2);
        check("t3_novl_count", 32'(bus0.match_count), 32'd2);
        do_stop();

        // 4: masked bit 0, then full mask, then with gaps
        seq4 = 5'b00011;
        configure(5'b00010, 5'b11110, 1'b1); do_start();
        zpulses = 0;
        for (int i = 0; i < W; i++) feed(seq4[i]);
        check("t4_masked", 32'(zpulses), 32'd1);
        do_stop();
        configure(5'b00010, 5'b11111, 1'b1); do_start();
        zpulses = 0;
        for (int i = 0; i < W; i++) feed(seq4[i]);
        check("t4_full", 32'(zpulses), 32'd0);
        do_stop();
        configure(5'b00010, 5'b11110, 1'b1); do_start();
        zpulses = 0;
        for (int i = 0; i < W; i++) begin feed(seq4[i]); tick(); tick(); end
        check("t4_gaps", 32'(zpulses), 32'd1);
        do_stop();

        // 5: 2-bit counter saturates; start clears
        configure(5'b00000, 5'b11111, 1'b1); do_start();
        for (int i = 0; i < 4; i++) feed(0);
        feed(0); check("t5_c1", 32'(bus1.match_count), 32'd1);
        feed(0); check("t5_c2", 32'(bus1.match_count), 32'd2);
        feed(0); check("t5_c3", 32'(bus1.match_count), 32'd3);
        check("t5_no_ovf", 32'(bus1.overflow), 32'd0);
        feed(0); check("t5_c4", 32'(bus1.match_count), 32'd3);
        check("t5_ovf", 32'(bus1.overflow), 32'd1);
        do_stop();
        check("t5_ovf_kept", 32'(bus1.overflow), 32'd1);
        do_start();
        check("t5_clr_cnt", 32'(bus1.match_count), 32'd0);
        check("t5_clr_ovf", 32'(bus1.overflow), 32'd0);

        // 6: config ignored in RUN, stop beats a completing hit, start+stop in IDLE
        for (int i = 0; i < W; i++) feed(0);
        s_cfg_valid = 1; s_cfg_pattern = 5'b11111; s_cfg_mask = 5'b11111; s_cfg_overlap = 0;
        check("t6_ready_low", 32'(bus0.cfg_ready), 32'd0);
        tick(); s_cfg_valid = 0;
        feed(0);
        check("t6_cfg_ignored_z", 32'(bus0.z), 32'd1);
        check("t6_still_armed", 32'(bus0.armed), 32'd1);
        s_stop = 1; s_in_valid = 1; s_in = 0; tick(); s_stop = 0; s_in_valid = 0;
        check("t6_stop_z", 32'(bus0.z), 32'd0);
        check("t6_stop_count", 32'(bus0.match_count), 32'd2);
        check("t6_stop_busy", 32'(bus0.busy), 32'd0);
        s_start = 1; s_stop = 1; tick(); s_start = 0; s_stop = 0;
        check("t6_start_stop", 32'(bus0.busy), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            s_cfg_valid   = ($urandom_range(0, 7) == 0);
            s_cfg_pattern = W'($urandom);
            s_cfg_mask    = W'($urandom & $urandom);
            s_cfg_overlap = 1'($urandom);
            s_start       = ($urandom_range(0, 5) == 0);
            s_stop        = ($urandom_range(0, 59) == 0);
            s_in_valid    = ($urandom_range(0, 3) != 0);
            s_in          = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
